// File: rtl/turn_pkg.sv
// turn_pkg: shared state encoding and sizing constants for the turn controller.
package turn_pkg;
    typedef enum logic [2:0] {IDLE, USER, CPU, TIMEOUT, DONE} state_t;
    localparam int TIMER_W           = 6;
    localparam int MAX_TIMEOUTS      = 3;
    localparam int TURN_SECS_DEFAULT = 60;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV enabled cycles; held at 0 while cleared or idle.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = enable && !clear && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear || !enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/turn_controller.sv
// turn_controller: alternates user/CPU turns, times the user turn in seconds,
// and forfeits the game after three consecutive user timeouts.
module turn_controller
    import turn_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int TURN_SECS = TURN_SECS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               user_move_done,
    input  logic               cpu_move_done,
    input  logic               game_over,
    output logic               user_turn,
    output logic               cpu_turn,
    output logic [TIMER_W-1:0] timer,
    output logic               time_out,
    output logic               forfeit
);
    localparam logic [TIMER_W-1:0] FULL = TIMER_W'(TURN_SECS);
    localparam logic [1:0]         MAXT = 2'(MAX_TIMEOUTS);

    state_t             state, state_n;
    logic [TIMER_W-1:0] timer_n;
    logic [1:0]         count, count_n;
    logic               forfeit_n;
    logic               tick;

    // Prescaler only runs in USER, so every entry into USER starts a fresh second.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != USER),
        .enable (state == USER),
        .tick   (tick)
    );

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        count_n   = count;
        forfeit_n = forfeit;
        case (state)
            IDLE: begin
                timer_n = FULL;
                if (start) begin
                    state_n   = USER;
                    count_n   = '0;
                    forfeit_n = 1'b0;
                end
            end
            USER: begin
                if (game_over) begin
                    state_n   = DONE;
                    forfeit_n = 1'b0;
                end else if (user_move_done) begin
                    state_n = CPU;
                    timer_n = FULL;
                    count_n = '0;
                end else if (tick) begin
                    timer_n = (timer > TIMER_W'(1)) ? timer - TIMER_W'(1) : '0;
                    if (timer <= TIMER_W'(1)) begin
                        state_n = TIMEOUT;
                        count_n = (count == MAXT) ? count : count + 2'd1;
                    end
                end
            end
            TIMEOUT: begin
                timer_n = '0;
                if (game_over) begin
                    state_n   = DONE;
                    forfeit_n = 1'b0;
                end else if (count == MAXT) begin
                    state_n   = DONE;
                    forfeit_n = 1'b1;
                end else begin
                    state_n = CPU;
                    timer_n = FULL;
                end
            end
            CPU: begin
                timer_n = FULL;
                if (game_over) begin
                    state_n   = DONE;
                    forfeit_n = 1'b0;
                end else if (cpu_move_done)
                    state_n = USER;
            end
            DONE: begin
                if (start) begin
                    state_n   = USER;
                    timer_n   = FULL;
                    count_n   = '0;
                    forfeit_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= FULL;
            count     <= '0;
            user_turn <= 1'b0;
            cpu_turn  <= 1'b0;
            time_out  <= 1'b0;
            forfeit   <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            count     <= count_n;
            user_turn <= (state_n == USER);
            cpu_turn  <= (state_n == CPU);
            time_out  <= (state_n == TIMEOUT);
            forfeit   <= forfeit_n;
        end
    end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed checks of turn timing, timeouts, forfeit, game_over and reset.
module tb_turn_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       user_move_done = 1'b0;
    logic       cpu_move_done = 1'b0;
    logic       game_over = 1'b0;
    logic       user_turn, cpu_turn, time_out, forfeit;
    logic [5:0] timer;
    int         n_checks = 0;
    int         n_fail = 0;

    turn_controller #(.TICK_DIV(4), .TURN_SECS(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .user_move_done (user_move_done),
        .cpu_move_done  (cpu_move_done),
        .game_over      (game_over),
        .user_turn      (user_turn),
        .cpu_turn       (cpu_turn),
        .timer          (timer),
        .time_out       (time_out),
        .forfeit        (forfeit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Called on the first USER cycle; walks the 12 cycles of a full turn and
    // leaves the bench on the cycle carrying the final tick (timer=1).
    task automatic user_turn_body(input string tag);
        for (int i = 0; i < 12; i++) begin
            check({tag, " timer"}, timer, 3 - i / 4);
            check({tag, " user_turn"}, user_turn, 1);
            check({tag, " time_out"}, time_out, 0);
            if (i < 11) next_cycle();
        end
    endtask

    // Pulse cpu_move_done from CPU and land on the first USER cycle.
    task automatic cpu_to_user();
        cpu_move_done = 1'b1;
        next_cycle();
        cpu_move_done = 1'b0;
    endtask

    initial begin
        next_cycle();
        check("rst user_turn", user_turn, 0);
        check("rst cpu_turn", cpu_turn, 0);
        check("rst timer", timer, 3);
        check("rst time_out", time_out, 0);
        check("rst forfeit", forfeit, 0);
        reset = 1'b1;
        next_cycle();
        check("idle user_turn", user_turn, 0);

        // Full user turn expiring into a timeout, then CPU.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        user_turn_body("t1");
        next_cycle();
        check("t1 time_out", time_out, 1);
        check("t1 timeout timer", timer, 0);
        check("t1 timeout user_turn", user_turn, 0);
        next_cycle();
        check("t1 time_out clears", time_out, 0);
        check("t1 cpu_turn", cpu_turn, 1);
        check("t1 cpu timer", timer, 3);

        // Move on the same cycle as the final tick wins.
        cpu_to_user();
        user_turn_body("race");
        user_move_done = 1'b1;
        next_cycle();
        user_move_done = 1'b0;
        check("race cpu_turn", cpu_turn, 1);
        check("race timer", timer, 3);
        check("race time_out", time_out, 0);
        next_cycle();
        check("race time_out later", time_out, 0);

        // Three consecutive timeouts forfeit the game.
        for (int k = 1; k <= 3; k++) begin
            cpu_to_user();
            user_turn_body($sformatf("to%0d", k));
            next_cycle();
            check($sformatf("to%0d time_out", k), time_out, 1);
            check($sformatf("to%0d forfeit pre", k), forfeit, 0);
            next_cycle();
            check($sformatf("to%0d cpu_turn", k), cpu_turn, k < 3 ? 1 : 0);
        end
        check("forfeit", forfeit, 1);
        check("forfeit user_turn", user_turn, 0);
        check("forfeit timer", timer, 0);
        next_cycle();
        check("done holds forfeit", forfeit, 1);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check("restart user_turn", user_turn, 1);
        check("restart forfeit", forfeit, 0);
        check("restart timer", timer, 3);

        // game_over beats user_move_done.
        game_over = 1'b1;
        user_move_done = 1'b1;
        next_cycle();
        game_over = 1'b0;
        user_move_done = 1'b0;
        check("go user_turn", user_turn, 0);
        check("go cpu_turn", cpu_turn, 0);
        check("go forfeit", forfeit, 0);
        check("go time_out", time_out, 0);
        next_cycle();
        check("go cpu_turn later", cpu_turn, 0);

        // Stray user_move_done in CPU is ignored.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        user_move_done = 1'b1;
        next_cycle();
        user_move_done = 1'b0;
        check("to cpu", cpu_turn, 1);
        user_move_done = 1'b1;
        next_cycle();
        user_move_done = 1'b0;
        check("stray umd cpu_turn", cpu_turn, 1);
        check("stray umd user_turn", user_turn, 0);
        check("stray umd timer", timer, 3);

        // Reset mid-turn with timer=2.
        cpu_to_user();
        repeat (4) next_cycle();
        check("pre-reset timer", timer, 2);
        #2 reset = 1'b0;
        #1;
        check("async user_turn", user_turn, 0);
        check("async cpu_turn", cpu_turn, 0);
        check("async timer", timer, 3);
        check("async time_out", time_out, 0);
        check("async forfeit", forfeit, 0);
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            check("post-reset time_out", time_out, 0);
            check("post-reset user_turn", user_turn, 0);
        end

        // Stray user_move_done in IDLE is ignored.
        user_move_done = 1'b1;
        next_cycle();
        user_move_done = 1'b0;
        check("idle umd user_turn", user_turn, 0);
        check("idle umd cpu_turn", cpu_turn, 0);
        check("idle umd timer", timer, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk cycles per one-second tick (legal 2..2^27).
REQ-002 Parameter TURN_SECS, default 60, turn length in seconds (legal 1..63).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  level; begins a game from IDLE or DONE.
REQ-006 user_move_done  input  1  one-cycle pulse; user committed a move.
REQ-007 cpu_move_done  input  1  one-cycle pulse; CPU committed a move.
REQ-008 game_over  input  1  one-cycle pulse; external win/draw detected.
REQ-009 user_turn  output  1  registered; high only in USER state.
REQ-010 cpu_turn  output  1  registered; high only in CPU state.
REQ-011 timer  output  6  registered; seconds remaining in the current user turn.
REQ-012 time_out  output  1  registered; one-cycle pulse per user timeout.
REQ-013 forfeit  output  1  registered; high in DONE when entered via three consecutive timeouts.

Function
REQ-014 FSM states SHALL be IDLE, USER, CPU, TIMEOUT, DONE.
REQ-015 IDLE: timer=TURN_SECS; start=1 -> USER next edge.
REQ-016 USER: prescaler counts 0..TICK_DIV-1; tick SHALL assert for one cycle when count=TICK_DIV-1, then count wraps to 0.
REQ-017 USER on tick: timer>1 -> timer-1; timer=1 -> timer=0 and next state TIMEOUT.
REQ-018 USER: user_move_done -> CPU; timer reloads to TURN_SECS; consecutive-timeout count clears to 0.
REQ-019 user_move_done on the same cycle as the final tick SHALL win: -> CPU, no time_out.
REQ-020 TIMEOUT SHALL last exactly one cycle with time_out=1, timer=0; consecutive-timeout count increments (2-bit, saturating at 3).
REQ-021 TIMEOUT exit: count reaches 3 -> DONE with forfeit=1; otherwise -> CPU with timer reloaded to TURN_SECS.
REQ-022 CPU: timer frozen at TURN_SECS; prescaler held at 0; cpu_move_done -> USER.
REQ-023 Every entry into USER SHALL clear the prescaler to 0, so each turn is exactly TURN_SECS*TICK_DIV cycles long.
REQ-024 game_over in USER, CPU or TIMEOUT SHALL take priority over all other inputs: -> DONE, forfeit=0, time_out=0 that cycle.
REQ-025 DONE: timer and forfeit held; start=1 -> USER with timer=TURN_SECS, forfeit=0, count=0.
REQ-026 start outside IDLE/DONE, user_move_done outside USER and cpu_move_done outside CPU SHALL be ignored.
REQ-027 Outputs are registered; each reflects a state change one cycle after the causing input is sampled.

Reset
REQ-028 reset=0 SHALL immediately force: state=IDLE, timer=TURN_SECS, prescaler=0, count=0, user_turn=0, cpu_turn=0, time_out=0, forfeit=0.
REQ-029 Reset asserted mid-turn SHALL abort the turn with no time_out pulse; after deassertion the block waits in IDLE for start.

Structure
REQ-030 Shared package turn_pkg SHALL hold the state enum, TIMER_W=6, MAX_TIMEOUTS=3 and the TURN_SECS default.
REQ-031 One sub-module, tick_prescaler (clk, reset, clear, enable -> tick), SHALL implement the one-second divider.
REQ-032 Timer decrement SHALL use 6-bit unsigned arithmetic and never underflow below 0.

Verification (TICK_DIV=4, TURN_SECS=3)
REQ-033 Reset, start pulse -> user_turn=1 next cycle; timer reads 3,2,1 at 4-cycle spacing; time_out pulses once when timer=0; cpu_turn=1 the next cycle with timer=3.
REQ-034 user_move_done in the same cycle as the final tick (timer=1) -> CPU, timer=3, time_out never asserts.
REQ-035 Three back-to-back user timeouts, each separated by a cpu_move_done -> DONE, forfeit=1, user_turn=0, cpu_turn=0; start -> USER, forfeit=0, timer=3.
REQ-036 game_over together with user_move_done in USER -> DONE, forfeit=0, cpu_turn stays 0.
REQ-037 reset=0 asserted with timer=2 in USER -> immediately state=IDLE, timer=3, all flags 0; no time_out after release.
REQ-038 user_move_done pulses in CPU and IDLE -> no state change, timer unchanged.
